imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory the CPU fetches from. It accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. It issues one write per word to the instruction memory's write port and holds the CPU core in reset while a load is in progress. It sits in the SoC top between an external byte source (debug/UART bridge) and the instruction memory write side.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address width; maximum load is 2^ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a load; sampled only in IDLE.
- len_i  in  ADDR_WIDTH+1  number of words to load; latched on accepted start.
- byte_i  in  8  stream byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- we_o  out  1  instruction-memory write enable, one cycle per word.
- waddr_o  out  32  byte address of the write, word aligned.
- wdata_o  out  32  write data.
- cpu_rst_o  out  1  reset to the CPU core; high during rst and while loading.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse at load completion.
- csum_err_o  out  1  checksum mismatch, sticky until the next accepted start.

## Operation
- States: IDLE, RECV, WRITE, CHECK. CHECK exists only with LOADER_CSUM_EN.
- IDLE:
  - start_i=1 latches len_i and clears word_cnt, byte_cnt and the sum. It also clears csum_err_o.
  - If len_i != 0, go to RECV.
  - If len_i == 0, stay in IDLE and pulse done_o next cycle. No write is issued.
- RECV:
  - byte_ready_o=1. A byte is accepted when byte_valid_i & byte_ready_o.
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k].
  - On the 4th accepted byte, go to WRITE.
- WRITE:
  - we_o=1 for exactly one cycle, with waddr_o = BASE_ADDR + 4*word_cnt and wdata_o = the assembled word. byte_ready_o=0.
  - Then word_cnt increments and byte_cnt clears.
  - If the written word was number len-1, go to IDLE, or to CHECK when the checksum is enabled. Otherwise return to RECV.
- Arithmetic: word_cnt is ADDR_WIDTH+1 bits. waddr_o uses 32-bit modulo arithmetic, so wrap past 2^32 is permitted and not flagged.
- busy_o = state != IDLE.
- cpu_rst_o is registered: 1 when rst is high or the next state is not IDLE. It falls in the same cycle done_o rises.
- start_i outside IDLE is ignored. byte_valid_i outside RECV is ignored; the byte is not consumed.
- rst mid-load aborts immediately:
  - Partial word discarded, no further writes.
  - All outputs return to their reset values.
  - No done_o pulse.
- Reset values: byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, csum_err_o=0.

## Timing
- Minimum 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- Back-pressure: byte_valid_i may drop at any point. byte_cnt holds and the partial word is retained.
- done_o is high in the cycle after the final WRITE, or after CHECK when enabled.
- cpu_rst_o:
  - Rises the cycle after an accepted start with len_i != 0.
  - Falls the cycle after rst deasserts when no load is pending.
- we_o, waddr_o and wdata_o are registered. waddr_o and wdata_o hold their last values when we_o=0.

## Configuration
- LOADER_CSUM_EN defined:
  - The sum is the 32-bit modulo sum of all written words.
  - After the last data word, RECV accepts one further 4-byte little-endian trailer. It is never written to memory.
  - In CHECK (1 cycle), csum_err_o is set if trailer != sum. Then go to IDLE with done_o.
- LOADER_CSUM_EN undefined: no trailer, no CHECK state, csum_err_o tied to 0.

## Test plan
- Reset, then idle 3 cycles -> cpu_rst_o=1 during rst and 0 from the first cycle after it. All other outputs 0.
- start with len=2, bytes 78 56 34 12 EF BE AD DE, valid every cycle -> we_o at addr 0x0 with 0x12345678, then addr 0x4 with 0xDEADBEEF. Writes are 5 cycles apart. done_o pulses once. cpu_rst_o falls with done_o.
- Same load with byte_valid_i toggling every other cycle -> identical writes and data, longer gaps, no lost or duplicated bytes.
- start with len=0 -> no we_o, done_o next cycle, cpu_rst_o stays 0.
- rst asserted after 6 bytes of a len=3 load -> exactly one write (word 0). No done_o. A fresh load afterwards starts at BASE_ADDR.
- LOADER_CSUM_EN, len=2 with the words above, trailer 0xF0E21567 -> csum_err_o=0. With trailer 0 -> csum_err_o=1, cleared on the next start.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Program loader for the instruction memory. A byte stream arriving over a
//   valid/ready handshake is packed little-endian into 32-bit words, and one
//   write is issued per word. The CPU core is held in reset while a load is
//   in progress.
//
//   Optional feature macro: LOADER_CSUM_EN
//     When defined, a 4-byte little-endian trailer follows the last data word.
//     The trailer is compared against the 32-bit modulo sum of all written
//     words, and csum_err_o reports a mismatch. When undefined, there is no
//     trailer and csum_err_o is tied low.
//
//   Parameters
//     ADDR_WIDTH  word-address width; a load is at most 2^ADDR_WIDTH words
//     BASE_ADDR   byte address of the first loaded word
//
//   Ports
//     clk, rst       clock; synchronous active-high reset
//     start_i        begin a load (sampled only while idle)
//     len_i          number of words to load, latched on an accepted start
//     byte_i         stream byte
//     byte_valid_i   byte_i valid
//     byte_ready_o   loader accepts a byte this cycle
//     we_o           instruction-memory write enable, one cycle per word
//     waddr_o        word-aligned byte address of the write
//     wdata_o        write data
//     cpu_rst_o      CPU core reset (high during rst and while loading)
//     busy_o         load in progress
//     done_o         one-cycle pulse at load completion
//     csum_err_o     sticky checksum mismatch, cleared by the next start
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_WIDTH:0] len_i,
  input  logic [7:0]          byte_i,
  input  logic                byte_valid_i,
  output logic                byte_ready_o,
  output logic                we_o,
  output logic [31:0]         waddr_o,
  output logic [31:0]         wdata_o,
  output logic                cpu_rst_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                csum_err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
`ifdef LOADER_CSUM_EN
  localparam logic [1:0] S_CHECK = 2'd3;
`endif

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [1:0]          byte_cnt;
  logic [31:0]         word_buf;
  logic [31:0]         asm_word;
  logic                accept;
  logic                last_byte;
  logic                last_word;
  // High while the four bytes being received are the checksum trailer.
  logic                in_trailer;
`ifdef LOADER_CSUM_EN
  logic [31:0]         sum_q;
`endif

  assign byte_ready_o = (state == S_RECV);
  assign busy_o       = (state != S_IDLE);
  assign accept       = byte_ready_o & byte_valid_i;
  assign last_byte    = accept & (byte_cnt == 2'd3);
  assign last_word    = ((word_cnt + CNT_ONE) == len_q);

  // The word as it looks once the byte on the bus is merged in; used so the
  // 4th byte can go straight into wdata_o without an extra cycle.
  always_comb begin
    asm_word = word_buf;
    asm_word[{byte_cnt, 3'b000} +: 8] = byte_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) state_nxt = S_RECV;
      end
      S_RECV: begin
        if (last_byte) begin
`ifdef LOADER_CSUM_EN
          state_nxt = in_trailer ? S_CHECK : S_WRITE;
`else
          state_nxt = S_WRITE;
`endif
        end
      end
      S_WRITE: begin
`ifdef LOADER_CSUM_EN
        // After the last data word the trailer is received in RECV.
        state_nxt = S_RECV;
`else
        state_nxt = last_word ? S_IDLE : S_RECV;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
`ifdef LOADER_CSUM_EN
      in_trailer <= 1'b0;
      csum_err_o <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cpu_rst_o <= (state_nxt != S_IDLE);
      we_o      <= 1'b0;
      done_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q    <= len_i;
            word_cnt <= '0;
            byte_cnt <= '0;
            if (len_i == '0) done_o <= 1'b1;
`ifdef LOADER_CSUM_EN
            in_trailer <= 1'b0;
            csum_err_o <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte && !in_trailer) begin
              we_o    <= 1'b1;
              waddr_o <= BASE_ADDR + (32'(word_cnt) << 2);
              wdata_o <= asm_word;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + CNT_ONE;
          byte_cnt <= '0;
          if (last_word) begin
`ifdef LOADER_CSUM_EN
            in_trailer <= 1'b1;
`else
            done_o <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CSUM_EN
        S_CHECK: begin
          csum_err_o <= (word_buf != sum_q);
          in_trailer <= 1'b0;
          done_o     <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath: byte packing and running sum, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (accept) word_buf[{byte_cnt, 3'b000} +: 8] <= byte_i;
`ifdef LOADER_CSUM_EN
    if ((state == S_IDLE) && start_i) sum_q <= '0;
    else if (state == S_WRITE)        sum_q <= sum_q + wdata_o;
`endif
  end

`ifndef LOADER_CSUM_EN
  assign in_trailer = 1'b0;
  assign csum_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. A transaction-level model derives
//   every output from the byte stream actually offered: a word completes on
//   every 4th accepted byte, is written in the following cycle, and done
//   follows the cycle after the final write (or trailer check). One compare
//   process checks all outputs on every falling edge; directed loads pin
//   literal addresses, data and timing.
module tb_imem_loader;

  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW:0]   len_i = '0;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic          we_o;
  logic [31:0]   waddr_o;
  logic [31:0]   wdata_o;
  logic          cpu_rst_o;
  logic          busy_o;
  logic          done_o;
  logic          csum_err_o;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .len_i        (len_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .csum_err_o   (csum_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle (start at reset values).
  logic        e_busy = 1'b0, e_ready = 1'b0, e_we = 1'b0, e_done = 1'b0;
  logic        e_cpu = 1'b1, e_err = 1'b0;
  logic [31:0] e_waddr = '0, e_wdata = '0;
  // Model bookkeeping.
  logic        n_busy, n_ready, n_we, n_done, n_cpu, n_err;
  logic [31:0] n_waddr, n_wdata;
  logic [7:0]  wb [4];
  logic [31:0] word, sum, trailer;
  int          lw, tot, acc;
  bit          fin;

  // Log of what the DUT actually wrote.
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    chk1 ("busy",       busy_o,       e_busy);
    chk1 ("byte_ready", byte_ready_o, e_ready);
    chk1 ("we",         we_o,         e_we);
    chk32("waddr",      waddr_o,      e_waddr);
    chk32("wdata",      wdata_o,      e_wdata);
    chk1 ("done",       done_o,       e_done);
    chk1 ("cpu_rst",    cpu_rst_o,    e_cpu);
    chk1 ("csum_err",   csum_err_o,   e_err);
    if (we_o === 1'b1) begin
      log_addr.push_back(waddr_o);
      log_data.push_back(wdata_o);
      log_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) done_cnt++;

    // Advance the model with the inputs the next rising edge will sample.
    n_busy = e_busy; n_ready = e_ready; n_we = 1'b0; n_done = 1'b0;
    n_waddr = e_waddr; n_wdata = e_wdata; n_err = e_err;
    if (rst) begin
      n_busy = 1'b0; n_ready = 1'b0; n_waddr = '0; n_wdata = '0; n_err = 1'b0;
      n_cpu = 1'b1; acc = 0; fin = 1'b0;
    end else begin
      if (!e_busy) begin
        if (start_i) begin
          n_err = 1'b0;
          lw = int'(len_i);
          if (lw == 0) n_done = 1'b1;
          else begin
            n_busy = 1'b1; n_ready = 1'b1;
            tot = 4 * lw;
            if (CSUM) tot += 4;
            acc = 0; sum = '0; fin = 1'b0;
          end
        end
      end else if (e_ready) begin
        if (byte_valid_i) begin
          wb[acc % 4] = byte_i;
          acc++;
          if (acc % 4 == 0) begin
            n_ready = 1'b0;
            word = {wb[3], wb[2], wb[1], wb[0]};
            if (acc <= 4 * lw) begin
              n_we = 1'b1;
              n_waddr = BASE + 32'(4 * (acc / 4 - 1));
              n_wdata = word;
              sum = sum + word;
            end else begin
              trailer = word;
            end
            if (acc == tot) fin = 1'b1;
          end
        end
      end else begin
        // Write (or trailer check) cycle: no byte taken.
        if (fin) begin
          n_done = 1'b1; n_busy = 1'b0;
          if (CSUM) n_err = (trailer != sum);
        end else begin
          n_ready = 1'b1;
        end
      end
      n_cpu = n_busy;
    end
    e_busy = n_busy; e_ready = n_ready; e_we = n_we; e_done = n_done;
    e_waddr = n_waddr; e_wdata = n_wdata; e_err = n_err; e_cpu = n_cpu;
  end

  logic [7:0] stim [$];

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
  endtask

  task automatic build_stim(input int len, input bit bad_trailer);
    logic [31:0] s, w;
    stim.delete();
    s = '0;
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      push_word(w);
      s = s + w;
    end
    if (CSUM) push_word(bad_trailer ? (s ^ 32'h0000_0100) : s);
  endtask

  // vmode 0: valid every cycle, 1: valid every other cycle,
  // 2: random valid plus stray start pulses while loading.
  task automatic run_load(input int len, input int vmode, input int stop_at);
    int idx, target, budget;
    target = (stop_at >= 0) ? stop_at : stim.size();
    idx = 0;
    budget = 0;
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i   = len[AW:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    while (idx < target && budget < 3000) begin
      byte_i = stim[idx];
      case (vmode)
        0: byte_valid_i = 1'b1;
        1: byte_valid_i = ~byte_valid_i;
        default: begin
          byte_valid_i = 1'($urandom_range(0, 1));
          start_i      = ($urandom_range(0, 3) == 0);
          len_i        = (AW + 1)'($urandom);
        end
      endcase
      @(negedge clk);
      if (byte_valid_i && byte_ready_o) idx++;
      @(posedge clk); #1;
      budget++;
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    chk32("bytes_accepted", 32'(idx), 32'(target));
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        chk1({name, "_cpu_rst_with_done"}, cpu_rst_o, 1'b0);
      end
    end
    chk1({name, "_done_seen"}, seen, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic load_directed();
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CSUM) push_word(32'hF0E2_1567);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int base, d0, len;

  initial begin
    // Reset, then idle.
    @(negedge clk);
    chk1("rst_cpu_rst", cpu_rst_o, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk1 ("idle_cpu_rst", cpu_rst_o, 1'b0);
    chk1 ("idle_busy",    busy_o,    1'b0);
    chk1 ("idle_ready",   byte_ready_o, 1'b0);
    chk32("idle_wdata",   wdata_o,   32'h0);
    @(posedge clk); #1;

    // Directed len=2, valid every cycle.
    load_directed();
    base = log_addr.size(); d0 = done_cnt;
    run_load(2, 0, -1);
    wait_done("t2");
    chk32("t2_nwrites", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() >= base + 2) begin
      chk32("t2_addr0", log_addr[base],     32'h0000_0000);
      chk32("t2_data0", log_data[base],     32'h1234_5678);
      chk32("t2_addr1", log_addr[base + 1], 32'h0000_0004);
      chk32("t2_data1", log_data[base + 1], 32'hDEAD_BEEF);
      chk32("t2_gap",   32'(log_cyc[base + 1] - log_cyc[base]), 32'd5);
    end
    chk32("t2_model_last", e_wdata, 32'hDEAD_BEEF);
    chk32("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk1 ("t2_csum_ok", csum_err_o, 1'b0);

    // Same load with byte_valid_i toggling.
    load_directed();
    base = log_addr.size(); d0 = done_cnt;
    run_load(2, 1, -1);
    wait_done("t3");
    chk32("t3_nwrites", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() >= base + 2) begin
      chk32("t3_data0", log_data[base],     32'h1234_5678);
      chk32("t3_data1", log_data[base + 1], 32'hDEAD_BEEF);
      chk1 ("t3_gap_longer", (log_cyc[base + 1] - log_cyc[base]) > 5, 1'b1);
    end
    chk32("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // len=0: no write, done next cycle.
    stim.delete();
    base = log_addr.size(); d0 = done_cnt;
    run_load(0, 0, -1);
    wait_done("t4");
    chk32("t4_nwrites", 32'(log_addr.size() - base), 32'd0);
    chk32("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // Abort after 6 bytes of a len=3 load.
    build_stim(3, 1'b0);
    base = log_addr.size(); d0 = done_cnt;
    run_load(3, 0, 6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk32("t5_nwrites", 32'(log_addr.size() - base), 32'd1);
    chk32("t5_no_done", 32'(done_cnt - d0), 32'd0);
    build_stim(1, 1'b0);
    base = log_addr.size();
    run_load(1, 0, -1);
    wait_done("t5b");
    if (log_addr.size() > base) chk32("t5_fresh_addr", log_addr[base], BASE);
    chk32("t5_fresh_nwrites", 32'(log_addr.size() - base), 32'd1);

`ifdef LOADER_CSUM_EN
    // Wrong trailer sets the sticky error; the next start clears it.
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
             8'h00, 8'h00, 8'h00, 8'h00};
    run_load(2, 0, -1);
    wait_done("t6");
    chk1("t6_csum_err", csum_err_o, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk1("t6_csum_sticky", csum_err_o, 1'b1);
    stim.delete();
    run_load(0, 0, -1);
    wait_done("t6b");
    chk1("t6_csum_cleared", csum_err_o, 1'b0);
`endif

    // Randomized loads including the maximum length and len=0.
    for (int t = 0; t < 16; t++) begin
      if (t == 0)      len = 1 << AW;
      else if (t == 5) len = 0;
      else             len = $urandom_range(1, 1 << AW);
      build_stim(len, (t % 3) == 1);
      d0 = done_cnt;
      run_load(len, 2, -1);
      wait_done("rand");
      chk32("rand_done_once", 32'(done_cnt - d0), 32'd1);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
